// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that merges an immediate into a base instruction
// word for the selected format and flags immediates that do not fit.
module imm_encoder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    base_instr,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [2:0]               ImmSrc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     range_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b011,
    FMT_U = 3'b100,
    FMT_J = 3'b101
  } imm_fmt_e;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_base;
  logic [DATA_WIDTH-1:0] s1_imm;
  logic [2:0]            s1_src;
  logic                  s2_valid;
  logic                  s2_load;
  logic                  s1_adv;
  logic [DATA_WIDTH-1:0] merged;
  logic                  merged_err;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_load;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_base  <= '0;
      s1_imm   <= '0;
      s1_src   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_base <= base_instr;
        s1_imm  <= imm;
        s1_src  <= ImmSrc;
      end
    end
  end

  // Out-of-range immediates are still merged from their truncated bits.
  always_comb begin
    merged     = s1_base;
    merged_err = 1'b0;
    case (s1_src)
      FMT_I: begin
        merged[31:20] = s1_imm[11:0];
        merged_err    = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_S: begin
        merged[31:25] = s1_imm[11:5];
        merged[11:7]  = s1_imm[4:0];
        merged_err    = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_B: begin
        merged[31]    = s1_imm[12];
        merged[30:25] = s1_imm[10:5];
        merged[11:8]  = s1_imm[4:1];
        merged[7]     = s1_imm[11];
        merged_err    = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
      end
      FMT_U: begin
        merged[31:12] = s1_imm[31:12];
        merged_err    = |s1_imm[11:0];
      end
      FMT_J: begin
        merged[31]    = s1_imm[20];
        merged[30:21] = s1_imm[10:1];
        merged[20]    = s1_imm[11];
        merged[19:12] = s1_imm[19:12];
        merged_err    = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
      end
      default: begin
        merged_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      instr     <= '0;
      range_err <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        instr     <= merged;
        range_err <= merged_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && range_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder: streamed tables plus hand-written
// latency, backpressure, saturation and asynchronous-reset sequences.
module tb_imm_encoder;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] base_instr;
  logic [DW-1:0] imm;
  logic [2:0]    imm_src;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] instr;
  logic          range_err;
  logic [CW-1:0] err_count;

  imm_encoder #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base_instr(base_instr),
    .imm       (imm),
    .ImmSrc    (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .range_err (range_err),
    .err_count (err_count)
  );

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;
  vec_t        stream[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s,
                              input logic [31:0] e, input logic er);
    vec_t v;
    v.base = b; v.imm = i; v.src = s; v.exp_instr = e; v.exp_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    base_instr = v.base;
    imm        = v.imm;
    imm_src    = v.src;
  endtask

  task automatic note_delivered(input vec_t v);
    if (v.exp_err && exp_cnt < 255) exp_cnt++;
  endtask

  // Streams the global vector queue with out_ready held high, scoreboarding in order.
  task automatic run_stream(input string tag, input bit chk_rate);
    int unsigned sent = 0;
    int unsigned got = 0;
    int unsigned cycles = 0;
    vec_t        pend[$];
    vec_t        v;
    out_ready = 1'b1;
    while (got < stream.size() && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (out_valid) begin
        if (pend.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_spurious actual=out_valid required=no_output", tag);
        end else begin
          v = pend.pop_front();
          check({tag, "_instr"}, instr, v.exp_instr);
          check({tag, "_err"}, {31'd0, range_err}, {31'd0, v.exp_err});
          note_delivered(v);
          got++;
        end
      end
      if (sent < stream.size()) begin
        drive(stream[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        pend.push_back(stream[sent]);
        sent++;
      end
    end
    in_valid = 1'b0;
    check({tag, "_delivered"}, got, stream.size());
    if (chk_rate) check({tag, "_cycles"}, cycles, stream.size() + 2);
    @(negedge clk);
    check({tag, "_err_count"}, {24'd0, err_count}, exp_cnt);
  endtask

  initial begin
    vec_t va, vb, vc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    base_instr = '0; imm = '0; imm_src = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_range_err", {31'd0, range_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // I-type latency: result visible after exactly two rising edges.
    @(negedge clk);
    out_ready = 1'b1;
    drive(mk(32'h00000093, 32'hFFFFFFFF, 3'b000, 32'h0, 1'b0));
    in_valid = 1'b1;
    #1 check("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_valid_1cyc", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid_2cyc", {31'd0, out_valid}, 32'd1);
    check("lat_instr", instr, 32'hFFF00093);
    check("lat_err", {31'd0, range_err}, 32'd0);
    @(negedge clk);
    check("lat_valid_after", {31'd0, out_valid}, 32'd0);
    check("lat_err_count", {24'd0, err_count}, 32'd0);

    // Four range errors.
    stream.delete();
    stream.push_back(mk(32'h00000093, 32'h00000800, 3'b000, 32'h80000093, 1'b1));
    stream.push_back(mk(32'h00000063, 32'h00000005, 3'b011, 32'h00000263, 1'b1));
    stream.push_back(mk(32'h00000037, 32'h00001001, 3'b100, 32'h00001037, 1'b1));
    stream.push_back(mk(32'h12345678, 32'h00000000, 3'b010, 32'h12345678, 1'b1));
    run_stream("rerr", 1'b1);
    check("rerr_count_four", {24'd0, err_count}, 32'd4);

    // Main format table, back-to-back.
    stream.delete();
    stream.push_back(mk(32'h0020A023, 32'h00000008, 3'b001, 32'h0020A423, 1'b0));
    stream.push_back(mk(32'h00000063, 32'hFFFFFFFC, 3'b011, 32'hFE000EE3, 1'b0));
    stream.push_back(mk(32'h0000006F, 32'hFFFFFFFC, 3'b101, 32'hFFDFF06F, 1'b0));
    stream.push_back(mk(32'h00000037, 32'h12345000, 3'b100, 32'h12345037, 1'b0));
    stream.push_back(mk(32'h0020A023, 32'hFFFFF800, 3'b001, 32'h8020A023, 1'b0));
    stream.push_back(mk(32'h0020A023, 32'hFFFFF7FF, 3'b001, 32'h7E20AFA3, 1'b1));
    stream.push_back(mk(32'h00000063, 32'h00000FFE, 3'b011, 32'h7E000FE3, 1'b0));
    stream.push_back(mk(32'h00000063, 32'h00001000, 3'b011, 32'h80000063, 1'b1));
    stream.push_back(mk(32'h0000006F, 32'h00000003, 3'b101, 32'h0020006F, 1'b1));
    stream.push_back(mk(32'hFFFFFFFF, 32'h00000000, 3'b000, 32'h000FFFFF, 1'b0));
    stream.push_back(mk(32'hDEADBEEF, 32'h00000005, 3'b111, 32'hDEADBEEF, 1'b1));
    stream.push_back(mk(32'h00000093, 32'h000007FF, 3'b000, 32'h7FF00093, 1'b0));
    stream.push_back(mk(32'h0000006F, 32'h000FFFFE, 3'b101, 32'h7FFFF06F, 1'b0));
    stream.push_back(mk(32'hFFFFFFB7, 32'hABCDE000, 3'b100, 32'hABCDEFB7, 1'b0));
    stream.push_back(mk(32'h0000006F, 32'h00100000, 3'b101, 32'h8000006F, 1'b1));
    run_stream("table", 1'b1);

    // Backpressure: out_ready low for four edges while three requests are offered.
    va = mk(32'hCAFEF00D, 32'h00000000, 3'b110, 32'hCAFEF00D, 1'b1);
    vb = mk(32'h0020A023, 32'h00000008, 3'b001, 32'h0020A423, 1'b0);
    vc = mk(32'h0000006F, 32'hFFFFFFFC, 3'b101, 32'hFFDFF06F, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(va); in_valid = 1'b1;
    #1 check("bp_ready_a", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(vb);
    #1 check("bp_ready_b", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(vc);
    #1 check("bp_ready_c_blocked", {31'd0, in_ready}, 32'd0);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_instr_a0", instr, va.exp_instr);
    check("bp_err_a0", {31'd0, range_err}, 32'd1);
    @(negedge clk);
    check("bp_instr_a1", instr, va.exp_instr);
    check("bp_ready_still_blocked", {31'd0, in_ready}, 32'd0);
    check("bp_count_stalled", {24'd0, err_count}, exp_cnt);
    @(negedge clk);
    check("bp_instr_a2", instr, va.exp_instr);
    out_ready = 1'b1;
    #1 check("bp_ready_c_accept", {31'd0, in_ready}, 32'd1);
    note_delivered(va);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_valid_b", {31'd0, out_valid}, 32'd1);
    check("bp_instr_b", instr, vb.exp_instr);
    check("bp_count_after_a", {24'd0, err_count}, exp_cnt);
    @(negedge clk);
    check("bp_valid_c", {31'd0, out_valid}, 32'd1);
    check("bp_instr_c", instr, vc.exp_instr);
    check("bp_err_c", {31'd0, range_err}, 32'd0);
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Saturation of the error counter.
    stream.delete();
    for (int unsigned i = 0; i < 260; i++)
      stream.push_back(mk(32'h00000013 + i, 32'h00000000, 3'b010, 32'h00000013 + i, 1'b1));
    run_stream("sat", 1'b0);
    check("sat_count_ff", {24'd0, err_count}, 32'h000000FF);

    // Asynchronous reset with both stages full and the consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    drive(va); in_valid = 1'b1;
    @(negedge clk);
    drive(vb);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_full_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {24'd0, err_count}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_err", {31'd0, range_err}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(vc); in_valid = 1'b1;
    #1 check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_valid_1cyc", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("post_rst_valid_2cyc", {31'd0, out_valid}, 32'd1);
    check("post_rst_instr", instr, vc.exp_instr);
    @(negedge clk);
    check("post_rst_no_ghost", {31'd0, out_valid}, 32'd0);
    check("post_rst_count", {24'd0, err_count}, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
